// File: rtl/dmem_store_buffer_pkg.sv
// Shared CPU package: opcode typedef, store-buffer defaults, drain FSM states.
package dmem_store_buffer_pkg;

  localparam int unsigned XLEN             = 64;
  localparam int unsigned WADDR_W          = 61;
  localparam int unsigned SB_DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_ALU    = 3'd3,
    OP_BRANCH = 3'd4
  } opcode_e;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_REQ  = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [XLEN-1:0]    data;
  } sb_entry_t;

  // Doubleword word address back to a byte address with the low bits cleared.
  function automatic logic [XLEN-1:0] word_to_byte_addr(input logic [WADDR_W-1:0] w);
    return {w, 3'b000};
  endfunction

endpackage

// File: rtl/dmem_store_buffer_sb_match.sv
// Youngest-match search over the circular buffer, oldest (head) to youngest.
module sb_match
  import dmem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]              valid_i,
  input  logic [DEPTH-1:0][WADDR_W-1:0] waddr_i,
  input  logic [PW-1:0]                 head_i,
  input  logic [WADDR_W-1:0]            key_i,
  output logic                          hit_o,
  output logic [PW-1:0]                 idx_o
);

  logic [PW-1:0] slot;

  // Walk from head forward; the last hit seen is the youngest entry.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_i + PW'(k);
      if (valid_i[slot] && (waddr_i[slot] == key_i)) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Coalescing data-memory store buffer with load forwarding and a two-state drain FSM.
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] address,
  input  logic            write_enable,
  input  logic            read_enable,
  input  logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] read_data,
  output logic            stall,
  output logic            buf_empty,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_wreq,
  input  logic            mem_wack,
  output logic [XLEN-1:0] mem_raddr,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  drain_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  sb_entry_t     entry_q [DEPTH];

  logic [WADDR_W-1:0]            word_addr_c;
  logic [DEPTH-1:0][WADDR_W-1:0] entry_waddr_c;
  logic [DEPTH-1:0]              valid_c;
  logic [DEPTH-1:0]              coal_valid_c;
  logic [PW-1:0]                 offset_c;
  logic                          fwd_hit_c, coal_hit_c;
  logic [PW-1:0]                 fwd_idx_c, coal_idx_c;
  logic                          full_c, store_c, push_c, coal_c, pop_c;
  logic                          unused_addr_lsb;

  assign word_addr_c     = address[XLEN-1:3];
  assign unused_addr_lsb = ^address[2:0];

  // Occupancy mask from head/count; the in-flight head is hidden from coalescing.
  always_comb begin
    valid_c       = '0;
    coal_valid_c  = '0;
    entry_waddr_c = '0;
    offset_c      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset_c         = PW'(i) - head_q;
      valid_c[i]       = (CW'(offset_c) < count_q);
      coal_valid_c[i]  = valid_c[i] && !((state_q == SB_REQ) && (PW'(i) == head_q));
      entry_waddr_c[i] = entry_q[i].waddr;
    end
  end

  sb_match #(.DEPTH(DEPTH)) u_fwd_match (
    .valid_i (valid_c),
    .waddr_i (entry_waddr_c),
    .head_i  (head_q),
    .key_i   (word_addr_c),
    .hit_o   (fwd_hit_c),
    .idx_o   (fwd_idx_c)
  );

  sb_match #(.DEPTH(DEPTH)) u_coal_match (
    .valid_i (coal_valid_c),
    .waddr_i (entry_waddr_c),
    .head_i  (head_q),
    .key_i   (word_addr_c),
    .hit_o   (coal_hit_c),
    .idx_o   (coal_idx_c)
  );

  // Store acceptance, coalesce/enqueue choice, pop and pointer/count updates.
  always_comb begin
    full_c  = (count_q == CW'(DEPTH));
    store_c = write_enable && !full_c;
    coal_c  = store_c && coal_hit_c;
    push_c  = store_c && !coal_hit_c;
    pop_c   = (state_q == SB_REQ) && mem_wack;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push_c && !pop_c) begin
      count_d = count_q + CW'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CW'(1);
    end
    if (push_c) begin
      tail_d = tail_q + PW'(1);
    end
    if (pop_c) begin
      head_d = head_q + PW'(1);
    end
  end

  // Drain FSM next state: start on a non-empty buffer, stop once the last entry pops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SB_IDLE: begin
        if (count_q != '0) begin
          state_d = SB_REQ;
        end
      end
      SB_REQ: begin
        if (pop_c && (count_d == '0)) begin
          state_d = SB_IDLE;
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  // Control state; reset abandons any in-flight drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SB_IDLE;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Entry storage; contents are qualified by the occupancy mask, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      entry_q[tail_q] <= '{waddr: word_addr_c, data: write_data};
    end else if (coal_c) begin
      entry_q[coal_idx_c].data <= write_data;
    end
  end

  // Outputs decoded from registered state and the addressed entries.
  always_comb begin
    stall     = write_enable && full_c;
    buf_empty = (count_q == '0) && (state_q == SB_IDLE);
    mem_wreq  = (state_q == SB_REQ);
    mem_waddr = '0;
    mem_wdata = '0;
    if (mem_wreq) begin
      mem_waddr = word_to_byte_addr(entry_q[head_q].waddr);
      mem_wdata = entry_q[head_q].data;
    end
    mem_raddr = word_to_byte_addr(word_addr_c);
    read_data = '0;
    if (read_enable) begin
      read_data = fwd_hit_c ? entry_q[fwd_idx_c].data : mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench: reference queue model acts as the scoreboard of pending backing writes.
module tb_dmem_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] address = '0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [63:0] write_data = '0;
  logic [63:0] read_data;
  logic        stall;
  logic        buf_empty;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic        mem_wreq;
  logic        mem_wack = 1'b0;
  logic [63:0] mem_raddr;
  logic [63:0] mem_rdata;

  logic [63:0] bmem    [32];
  logic [63:0] exp_mem [32];

  typedef struct {
    logic [60:0] wa;
    logic [63:0] d;
  } ent_t;

  ent_t m_q[$];
  bit   m_req;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  assign mem_rdata = bmem[mem_raddr[7:3]];

  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .stall        (stall),
    .buf_empty    (buf_empty),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wreq     (mem_wreq),
    .mem_wack     (mem_wack),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_read(input logic [63:0] a);
    logic [60:0] wa;
    wa = a[63:3];
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i].wa == wa) return m_q[i].d;
    end
    return exp_mem[wa[4:0]];
  endfunction

  // One clock: drive at negedge, check combinational outputs, advance the model.
  task automatic cyc(input bit we, input bit re, input logic [63:0] a,
                     input logic [63:0] wd, input bit wack);
    bit          stall_e, pop, push;
    int          idx, lo, size_before;
    logic [60:0] wa;
    @(negedge clk);
    write_enable = we;
    read_enable  = re;
    address      = a;
    write_data   = wd;
    mem_wack     = wack;
    #1;
    wa      = a[63:3];
    stall_e = we && (m_q.size() == DEPTH);
    check("stall", 64'(stall), 64'(stall_e));
    check("wreq", 64'(mem_wreq), 64'(m_req));
    check("empty", 64'(buf_empty), 64'((m_q.size() == 0) && !m_req));
    check("rdata", read_data, re ? exp_read(a) : 64'd0);
    check("raddr", mem_raddr, {a[63:3], 3'b000});
    if (m_req) begin
      check("waddr", mem_waddr, {m_q[0].wa, 3'b000});
      check("wdata", mem_wdata, m_q[0].d);
    end
    if (mem_wreq && wack) bmem[mem_waddr[7:3]] = mem_wdata;
    pop         = m_req && wack;
    size_before = m_q.size();
    push        = 1'b0;
    if (we && !stall_e) begin
      idx = -1;
      lo  = m_req ? 1 : 0;
      for (int i = m_q.size() - 1; i >= lo; i--) begin
        if (m_q[i].wa == wa) begin
          idx = i;
          break;
        end
      end
      if (idx >= 0) m_q[idx].d = wd;
      else push = 1'b1;
    end
    if (pop) begin
      exp_mem[m_q[0].wa[4:0]] = m_q[0].d;
      void'(m_q.pop_front());
    end
    if (push) m_q.push_back('{wa: wa, d: wd});
    m_req = m_req ? (m_q.size() > 0) : (size_before > 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (m_q.size() > 0 || m_req); i++) cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
    @(negedge clk);
    write_enable = 1'b0;
    mem_wack     = 1'b0;
    #1;
    check("drained", 64'(buf_empty), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      bmem[i]    = '0;
      exp_mem[i] = '0;
    end
    bmem[6]    = 64'd7;
    exp_mem[6] = 64'd7;
    m_req      = 1'b0;

    // Reset state
    #3;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_empty", 64'(buf_empty), 64'd1);
    check("rst_wreq", 64'(mem_wreq), 64'd0);
    check("rst_waddr", mem_waddr, 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two stores held in the buffer, forwarded load, head presented to memory
    cyc(1, 0, 64'h10, 64'hAA, 0);
    cyc(1, 0, 64'h18, 64'hBB, 0);
    cyc(0, 1, 64'h10, 64'h0, 0);
    check("fwd_0x10", read_data, 64'hAA);
    check("head_0x10", mem_waddr, 64'h10);
    drain();

    // Full buffer stalls; one ack frees a slot only on the following cycle
    cyc(1, 0, 64'h40, 64'h1, 0);
    cyc(1, 0, 64'h48, 64'h2, 0);
    cyc(1, 0, 64'h50, 64'h3, 0);
    cyc(1, 0, 64'h58, 64'h4, 0);
    cyc(1, 0, 64'h60, 64'h5, 0);
    cyc(1, 0, 64'h60, 64'h5, 1);
    cyc(1, 0, 64'h60, 64'h5, 0);
    drain();

    // No coalescing into the in-flight head; later store merges into the youngest
    cyc(1, 0, 64'h20, 64'd1, 0);
    cyc(0, 0, 64'h0, 64'd0, 0);
    cyc(1, 0, 64'h20, 64'd2, 0);
    cyc(1, 0, 64'h20, 64'd3, 0);
    cyc(0, 1, 64'h20, 64'd0, 0);
    drain();
    check("bk_0x20", bmem[4], 64'd3);

    // Same-cycle store and load see the old value
    cyc(1, 1, 64'h30, 64'd5, 0);
    cyc(0, 1, 64'h30, 64'd0, 0);
    drain();

    // Random traffic with low address bits that must be ignored
    for (int n = 0; n < 80; n++) begin
      cyc(1'($urandom % 2), 1'($urandom % 2), 64'h80 + 64'(8 * ($urandom % 4)) + 64'($urandom % 8),
          {32'($urandom), 32'($urandom)}, ($urandom % 3) != 0);
    end
    drain();

    // Asynchronous reset mid-drain abandons all entries
    cyc(1, 0, 64'hA0, 64'h11, 0);
    cyc(1, 0, 64'hA8, 64'h22, 0);
    cyc(1, 0, 64'hB0, 64'h33, 0);
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    #1;
    check("pre_rst_wreq", 64'(mem_wreq), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_wreq", 64'(mem_wreq), 64'd0);
    check("arst_empty", 64'(buf_empty), 64'd1);
    check("arst_stall", 64'(stall), 64'd0);
    check("arst_waddr", mem_waddr, 64'd0);
    check("arst_wdata", mem_wdata, 64'd0);
    m_q.delete();
    m_req    = 1'b0;
    mem_wack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 64'h0, 64'h0, 1);
    cyc(0, 0, 64'h0, 64'h0, 1);
    cyc(0, 1, 64'hA0, 64'h0, 1);
    cyc(0, 1, 64'hA8, 64'h0, 0);
    check("bk_0xA0", bmem[20], 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
